// File: rtl/tube_pkg.sv
// Shared encodings and helpers for the scrolling tube field.
package tube_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // A zero speed setting would stall the field, so it moves at least one pixel.
    function automatic logic [2:0] speed_step(input logic [2:0] speed);
        return (speed == 3'd0) ? 3'd1 : speed;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR used for tube gap heights.
module lfsr16
    import tube_pkg::*;
(
    input  logic        clk_10,
    input  logic        clr,
    output logic [15:0] q
);

    always_ff @(posedge clk_10 or negedge clr) begin
        if (!clr) begin
            q <= LFSR_SEED;
        end else if (q[0]) begin
            q <= (q >> 1) ^ LFSR_TAPS;
        end else begin
            q <= q >> 1;
        end
    end

endmodule

// File: rtl/tube_field.sv
// Scrolling obstacle field: NUM_TUBES tubes moving left, wrapping with random
// gap heights, plus game state machine and saturating score counter.
module tube_field
    import tube_pkg::*;
#(
    parameter int NUM_TUBES    = 3,
    parameter int COORD_W      = 10,
    parameter int START_X      = 400,
    parameter int TUBE_SPACING = 200,
    parameter int TUBE_W       = 50,
    parameter int BIRD_X       = 200,
    parameter int Y_MIN        = 80,
    parameter int Y_RANGE_LOG2 = 7
) (
    input  logic                         clk_10,
    input  logic                         clr,
    input  logic                         start,
    input  logic                         pause,
    input  logic                         over,
    input  logic [2:0]                   speed,
    output logic [NUM_TUBES*COORD_W-1:0] tube_x,
    output logic [NUM_TUBES*COORD_W-1:0] tube_y,
    output logic                         score,
    output logic [15:0]                  score_cnt,
    output logic [1:0]                   state
);

    localparam int W = COORD_W;
    localparam logic [W-1:0] Y_MID    = W'(Y_MIN + 2 ** (Y_RANGE_LOG2 - 1));
    localparam logic [W:0]   FIELD_LEN = (W+1)'(NUM_TUBES * TUBE_SPACING);

    state_t state_reg, state_next;
    logic   reload;
    logic   run_tick;
    logic [15:0] lfsr_q;
    logic        unused_lfsr;
    logic [W-1:0] step;
    logic [W-1:0] wrap_y;
    logic [NUM_TUBES-1:0] hit;

    lfsr16 u_lfsr (
        .clk_10 (clk_10),
        .clr    (clr),
        .q      (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q;
    assign step        = W'(speed_step(speed));
    assign wrap_y      = W'(Y_MIN) + W'(lfsr_q[Y_RANGE_LOG2-1:0]);
    assign run_tick    = (state_reg == ST_RUN) && !pause;
    assign state       = state_reg;

    always_ff @(posedge clk_10 or negedge clr) begin
        if (!clr) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // over takes priority over start in every state.
    always_comb begin
        state_next = state_reg;
        reload     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (over) begin
                    state_next = ST_OVER;
                end else if (start) begin
                    state_next = ST_RUN;
                    reload     = 1'b1;
                end
            end
            ST_RUN: begin
                if (over) begin
                    state_next = ST_OVER;
                end
            end
            ST_OVER: begin
                if (!over && start) begin
                    state_next = ST_RUN;
                    reload     = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_TUBES; gi++) begin : g_tube
            localparam logic [W-1:0] X_INIT = W'(START_X + gi * TUBE_SPACING);
            logic [W-1:0] x_reg, y_reg, x_new;
            logic [W:0]   old_re, new_re;
            logic         wrap;

            assign wrap   = x_reg < step;
            // Wrapping adds the full field length so tube spacing stays exact.
            assign x_new  = wrap ? W'({1'b0, x_reg} + FIELD_LEN - {1'b0, step})
                                 : x_reg - step;
            assign old_re = {1'b0, x_reg} + (W+1)'(TUBE_W);
            assign new_re = {1'b0, x_new} + (W+1)'(TUBE_W);
            assign hit[gi] = !wrap && (old_re > (W+1)'(BIRD_X))
                                   && (new_re <= (W+1)'(BIRD_X));

            always_ff @(posedge clk_10 or negedge clr) begin
                if (!clr) begin
                    x_reg <= X_INIT;
                    y_reg <= Y_MID;
                end else if (reload) begin
                    x_reg <= X_INIT;
                    y_reg <= Y_MID;
                end else if (run_tick) begin
                    x_reg <= x_new;
                    if (wrap) begin
                        y_reg <= wrap_y;
                    end
                end
            end

            assign tube_x[gi*W +: W] = x_reg;
            assign tube_y[gi*W +: W] = y_reg;
        end
    endgenerate

    always_ff @(posedge clk_10 or negedge clr) begin
        if (!clr) begin
            score     <= 1'b0;
            score_cnt <= 16'd0;
        end else begin
            score <= run_tick && (|hit);
            if (reload) begin
                score_cnt <= 16'd0;
            end else if (run_tick && (|hit) && (score_cnt != 16'hFFFF)) begin
                score_cnt <= score_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tube_field.sv
// Directed self-checking bench for tube_field with default parameters.
module tb_tube_field;

    logic        clk_10;
    logic        clr;
    logic        start;
    logic        pause;
    logic        over;
    logic [2:0]  speed;
    logic [29:0] tube_x;
    logic [29:0] tube_y;
    logic        score;
    logic [15:0] score_cnt;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;
    logic [15:0] m;
    logic [9:0]  exp_y;
    int          pulses;

    tube_field dut (
        .clk_10    (clk_10),
        .clr       (clr),
        .start     (start),
        .pause     (pause),
        .over      (over),
        .speed     (speed),
        .tube_x    (tube_x),
        .tube_y    (tube_y),
        .score     (score),
        .score_cnt (score_cnt),
        .state     (state)
    );

    initial clk_10 = 1'b0;
    always #5 clk_10 = ~clk_10;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Reference LFSR stepped on the same edges as the design.
    always @(posedge clk_10 or negedge clr) begin
        if (!clr) m <= 16'hACE1;
        else      m <= lfsr_step(m);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_10);
    endtask

    initial begin
        clr = 1'b0; start = 1'b0; pause = 1'b0; over = 1'b0; speed = 3'd1;
        #12;
        chk("rst_state", 32'(state), 0);
        chk("rst_x0", 32'(tube_x[9:0]), 400);
        chk("rst_x1", 32'(tube_x[19:10]), 600);
        chk("rst_x2", 32'(tube_x[29:20]), 800);
        chk("rst_y0", 32'(tube_y[9:0]), 144);
        chk("rst_y2", 32'(tube_y[29:20]), 144);
        chk("rst_score", 32'(score), 0);
        chk("rst_cnt", 32'(score_cnt), 0);
        @(negedge clk_10);
        clr = 1'b1;

        // start from IDLE, speed 1
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("start_state", 32'(state), 1);
        chk("start_x0_hold", 32'(tube_x[9:0]), 400);
        tick(1);
        chk("run1_x0", 32'(tube_x[9:0]), 399);
        chk("run1_x1", 32'(tube_x[19:10]), 599);
        chk("run1_x2", 32'(tube_x[29:20]), 799);

        pulses = 0;
        for (int t = 2; t <= 249; t++) begin
            tick(1);
            if (score) pulses++;
        end
        chk("no_early_score", 32'(pulses), 0);
        tick(1);
        chk("t250_score", 32'(score), 1);
        chk("t250_x0", 32'(tube_x[9:0]), 150);
        chk("t250_cnt", 32'(score_cnt), 1);
        tick(1);
        chk("t251_score_off", 32'(score), 0);

        tick(149);
        chk("t400_x0", 32'(tube_x[9:0]), 0);
        chk("t400_y0", 32'(tube_y[9:0]), 144);
        chk("t400_cnt", 32'(score_cnt), 1);
        exp_y = 10'd80 + 10'(m[6:0]);
        tick(1);
        chk("wrap_x0", 32'(tube_x[9:0]), 599);
        chk("wrap_y0", 32'(tube_y[9:0]), 32'(exp_y));
        chk("wrap_y0_range", 32'(tube_y[9:0] >= 10'd80 && tube_y[9:0] <= 10'd207), 1);
        chk("wrap_x1", 32'(tube_x[19:10]), 199);
        chk("wrap_x2", 32'(tube_x[29:20]), 399);
        chk("wrap_no_score", 32'(score), 0);

        // speed 0 behaves as 1
        speed = 3'd0;
        tick(1);
        chk("spd0_x0", 32'(tube_x[9:0]), 598);

        // speed 7: 598 -> 3 in 85 ticks, then wraps to 596
        speed = 3'd7;
        tick(85);
        chk("spd7_x0", 32'(tube_x[9:0]), 3);
        chk("spd7_x1", 32'(tube_x[19:10]), 203);
        chk("spd7_x2", 32'(tube_x[29:20]), 403);
        exp_y = 10'd80 + 10'(m[6:0]);
        tick(1);
        chk("spd7_wrap_x0", 32'(tube_x[9:0]), 596);
        chk("spd7_wrap_y0", 32'(tube_y[9:0]), 32'(exp_y));
        chk("spd7_x1b", 32'(tube_x[19:10]), 196);
        chk("spd7_x2b", 32'(tube_x[29:20]), 396);

        // pause for 20 ticks
        speed = 3'd1;
        pause = 1'b1;
        pulses = 0;
        for (int t = 0; t < 20; t++) begin
            tick(1);
            if (score) pulses++;
            if (tube_x[9:0] != 10'd596 || tube_x[19:10] != 10'd196 || tube_x[29:20] != 10'd396
                || tube_y[9:0] != exp_y) pulses++;
        end
        chk("pause_frozen", 32'(pulses), 0);
        chk("pause_state", 32'(state), 1);
        pause = 1'b0;
        tick(1);
        chk("resume_x0", 32'(tube_x[9:0]), 595);

        // over and start together in RUN (paused so positions are unambiguous)
        pause = 1'b1; over = 1'b1; start = 1'b1;
        tick(1);
        over = 1'b0; start = 1'b0; pause = 1'b0;
        chk("over_wins", 32'(state), 2);
        tick(3);
        chk("over_hold_x0", 32'(tube_x[9:0]), 595);
        chk("over_hold_state", 32'(state), 2);
        chk("over_score", 32'(score), 0);

        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("restart_state", 32'(state), 1);
        chk("restart_x0", 32'(tube_x[9:0]), 400);
        chk("restart_x1", 32'(tube_x[19:10]), 600);
        chk("restart_x2", 32'(tube_x[29:20]), 800);
        chk("restart_y0", 32'(tube_y[9:0]), 144);
        chk("restart_cnt", 32'(score_cnt), 0);
        tick(1);
        chk("restart_run_x0", 32'(tube_x[9:0]), 399);
        tick(249);
        chk("rerun_cnt", 32'(score_cnt), 1);
        chk("rerun_x0", 32'(tube_x[9:0]), 150);

        // asynchronous reset mid-run
        #2 clr = 1'b0;
        #1;
        chk("async_state", 32'(state), 0);
        chk("async_x0", 32'(tube_x[9:0]), 400);
        chk("async_x2", 32'(tube_x[29:20]), 800);
        chk("async_y0", 32'(tube_y[9:0]), 144);
        chk("async_cnt", 32'(score_cnt), 0);
        chk("async_score", 32'(score), 0);
        @(negedge clk_10);
        clr = 1'b1;

        // over from IDLE goes to OVER
        over = 1'b1;
        tick(1);
        over = 1'b0;
        chk("idle_over", 32'(state), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
